// File: rtl/srio_nwr_segmenter.sv
// Splits one user packet into NWRITE segments of at most MAX_PAYLOAD bytes.
// Each segment gets an address/length request and its completion is awaited before the next.
module srio_nwr_segmenter #(
    parameter int MAX_PAYLOAD = 256,
    parameter int ADDR_W      = 34
) (
    input  logic              clk_srio,
    input  logic              reset_srio,
    input  logic              nwr_req_in,
    input  logic [ADDR_W-1:0] user_taddr_in,
    input  logic [15:0]       user_tlen_in,
    input  logic [63:0]       user_tdata_in,
    input  logic              user_tvalid_in,
    input  logic              user_tfirst_in,
    input  logic [7:0]        user_tkeep_in,
    input  logic              user_tlast_in,
    output logic              user_tready_out,
    output logic              seg_req_out,
    input  logic              seg_req_ready_in,
    output logic [ADDR_W-1:0] seg_addr_out,
    output logic [8:0]        seg_len_out,
    output logic [63:0]       seg_tdata_out,
    output logic              seg_tvalid_out,
    output logic              seg_tfirst_out,
    output logic [7:0]        seg_tkeep_out,
    output logic              seg_tlast_out,
    input  logic              seg_tready_in,
    input  logic              seg_done_in,
    output logic              busy_out,
    output logic              pkt_done_out,
    output logic              len_err_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    function automatic logic [8:0] clip_len(input logic [15:0] rem);
        logic [8:0] len;
        if (rem > MAX_LEN) begin
            len = MAX_LEN[8:0];
        end else begin
            len = rem[8:0];
        end
        return len;
    endfunction

    function automatic logic [5:0] beats_of(input logic [8:0] len);
        return 6'((len + 9'd7) >> 3'd3);
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [15:0]       remaining_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] seg_addr_r;
    logic [8:0]        seg_len_r;
    logic [5:0]        seg_beats_r;
    logic [5:0]        beat_cnt_r;
    logic              seg_req_r;
    logic              pkt_done_r;
    logic              len_err_r;
    logic              busy_r;
    logic              abort_r;
    logic              drain_r;

    logic              in_data_s;
    logic              xfer_s;
    logic              last_beat_s;
    logic              last_seg_s;
    logic [15:0]       rem_after_s;
    logic [8:0]        clip_s;
    logic              unused_tfirst_s;

    assign unused_tfirst_s = user_tfirst_in;

    assign in_data_s   = (state_r == ST_DATA);
    assign xfer_s      = in_data_s & user_tvalid_in & seg_tready_in;
    assign last_beat_s = (beat_cnt_r == (seg_beats_r - 6'd1));
    assign last_seg_s  = (remaining_r == {7'd0, seg_len_r});
    assign rem_after_s = remaining_r - {7'd0, seg_len_r};
    assign clip_s      = clip_len(remaining_r);

    // Data path is a combinational pass-through gated by the FSM phase
    assign seg_tdata_out   = user_tdata_in;
    assign seg_tkeep_out   = user_tkeep_in;
    assign seg_tvalid_out  = user_tvalid_in & in_data_s;
    assign user_tready_out = (in_data_s & seg_tready_in) | (state_r == ST_DRAIN);
    assign seg_tfirst_out  = in_data_s & (beat_cnt_r == 6'd0);
    assign seg_tlast_out   = in_data_s & (last_beat_s | (user_tvalid_in & user_tlast_in));

    assign seg_req_out  = seg_req_r;
    assign seg_addr_out = seg_addr_r;
    assign seg_len_out  = seg_len_r;
    assign busy_out     = busy_r;
    assign pkt_done_out = pkt_done_r;
    assign len_err_out  = len_err_r;

    // Next-state decode for the segmenting FSM
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (nwr_req_in && (user_tlen_in != 16'd0)) begin
                    next_state_s = ST_REQ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (seg_req_r && seg_req_ready_in) begin
                    next_state_s = ST_DATA;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DATA: begin
                if (xfer_s && (user_tlast_in || last_beat_s)) begin
                    next_state_s = ST_WAIT;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (!seg_done_in) begin
                    next_state_s = ST_WAIT;
                end else if (abort_r) begin
                    next_state_s = ST_IDLE;
                end else if (drain_r) begin
                    next_state_s = ST_DRAIN;
                end else if (rem_after_s == 16'd0) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (user_tvalid_in && user_tlast_in) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_srio) begin
        if (reset_srio) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Packet bookkeeping, request fields and status flags
    always_ff @(posedge clk_srio) begin
        if (reset_srio) begin
            remaining_r <= 16'd0;
            addr_r      <= '0;
            seg_addr_r  <= '0;
            seg_len_r   <= 9'd0;
            seg_beats_r <= 6'd0;
            beat_cnt_r  <= 6'd0;
            seg_req_r   <= 1'b0;
            pkt_done_r  <= 1'b0;
            len_err_r   <= 1'b0;
            busy_r      <= 1'b0;
            abort_r     <= 1'b0;
            drain_r     <= 1'b0;
        end else begin
            pkt_done_r <= 1'b0;
            busy_r     <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (nwr_req_in && (user_tlen_in != 16'd0)) begin
                        remaining_r <= user_tlen_in;
                        addr_r      <= user_taddr_in;
                        abort_r     <= 1'b0;
                        drain_r     <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Request rises one cycle after entering REQ and holds until accepted
                    if (!seg_req_r) begin
                        seg_req_r   <= 1'b1;
                        seg_len_r   <= clip_s;
                        seg_addr_r  <= addr_r;
                        seg_beats_r <= beats_of(clip_s);
                    end else if (seg_req_ready_in) begin
                        seg_req_r  <= 1'b0;
                        beat_cnt_r <= 6'd0;
                    end
                end
                ST_DATA: begin
                    if (xfer_s) begin
                        if (user_tlast_in) begin
                            if (!(last_beat_s && last_seg_s)) begin
                                len_err_r <= 1'b1;
                                abort_r   <= 1'b1;
                            end
                        end else if (last_beat_s) begin
                            if (last_seg_s) begin
                                len_err_r <= 1'b1;
                                drain_r   <= 1'b1;
                            end
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 6'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (seg_done_in) begin
                        remaining_r <= rem_after_s;
                        addr_r      <= addr_r + ADDR_W'(seg_len_r);
                        if (!abort_r && !drain_r && (rem_after_s == 16'd0)) begin
                            pkt_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
